instr_fetch_unit: RTL and testbench

//  Upstream stage of control_unit. Reads instruction words from main_memory and buffers them
//  in a small prefetch FIFO; presents them to decode over a valid/ready handshake with their PC.

---
 rtl/instr_fetch_unit_pkg.sv | 23 ++
 rtl/instr_fetch_unit_if.sv | 32 +++
 rtl/instr_fetch_unit_fifo.sv | 72 +++++++
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: fetch FSM states and
// the opcode map that decode in control_unit uses as well.
package instr_fetch_unit_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } ifu_state_t;

  // Opcode field is the top three bits of every instruction word
  localparam logic [2:0] OPC_ADD   = 3'b000;
  localparam logic [2:0] OPC_SUB   = 3'b001;
  localparam logic [2:0] OPC_MUL   = 3'b010;
  localparam logic [2:0] OPC_DIV   = 3'b011;
  localparam logic [2:0] OPC_LOAD  = 3'b100;
  localparam logic [2:0] OPC_STORE = 3'b101;
  localparam logic [2:0] OPC_HALT  = 3'b111;

  localparam int OPC_W = 3;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory, decode and control-unit signals.
// The master modport is the fetch unit's own view; slave is the view of
// the surrounding memory / decode / control logic.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              start;
  logic              mem_busy;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read_enable;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              fetch_active;

  modport master (
    input  start, mem_busy, mem_data_out, instr_ready, redirect_valid, redirect_pc,
    output mem_address, mem_read_enable, instr, instr_pc, instr_valid, fetch_active
  );

  modport slave (
    output start, mem_busy, mem_data_out, instr_ready, redirect_valid, redirect_pc,
    input  mem_address, mem_read_enable, instr, instr_pc, instr_valid, fetch_active
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// ifu_fifo: small synchronous prefetch FIFO holding {pc, instruction} pairs.
// Clear wins over push and pop; pop of an empty FIFO and push into a full
// FIFO (without a simultaneous pop) are ignored. The head entry reads out
// as zero while the FIFO is empty.
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W-1:0] wrPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  assign doPop   = pop_i && (count_q != '0);
  assign doPush  = push_i && ((count_q != CNT_W'(DEPTH)) || doPop);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];

  // Storage array: written at the tail on every accepted push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (doPush && !clear_i) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instruction words from main memory into a
// prefetch FIFO and hands them to decode with their PC over valid/ready.
// At most one read is outstanding; a read is only issued when the FIFO has
// room, so the returning word always has a slot. A redirect flushes the
// FIFO and restarts fetch at the new PC, dropping any read still in flight.
// Optional feature: define IFU_HALT_DETECT_EN to stop fetching (back to
// IDLE) after a HALT-opcode word has been captured.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 16,
  parameter int              DEPTH    = 4,
  parameter int              MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_W + DATA_W;

  ifu_state_t        state_q,  state_d;
  logic [ADDR_W-1:0] pc_q,     pc_d;
  logic [ADDR_W-1:0] reqPc_q,  reqPc_d;
  logic [LAT_W-1:0]  latCnt_q, latCnt_d;
  logic              squash_q, squash_d;

  logic              issue;
  logic              capture;
  logic              pushEn;
  logic [CNT_W-1:0]  fifoCount;
  logic              fifoEmpty;
  logic [ENT_W-1:0]  fifoHead;

  // Sequencer, PC and squash registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      reqPc_q  <= '0;
      latCnt_q <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      reqPc_q  <= reqPc_d;
      latCnt_q <= latCnt_d;
      squash_q <= squash_d;
    end
  end

  // Next-state logic: issue/wait sequencing with redirect taking priority
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    reqPc_d  = reqPc_q;
    latCnt_d = latCnt_q;
    squash_d = squash_q;
    issue    = 1'b0;
    capture  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!bus.redirect_valid && !bus.mem_busy && (fifoCount < CNT_W'(DEPTH))) begin
          issue    = 1'b1;
          reqPc_d  = pc_q;
          pc_d     = pc_q + ADDR_W'(1);
          latCnt_d = LAT_W'(MEM_LAT - 1);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (latCnt_q == '0) begin
          capture  = 1'b1;
          squash_d = 1'b0;
          state_d  = ST_ISSUE;
        end else begin
          latCnt_d = latCnt_q - LAT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    pushEn = capture && !squash_q && !bus.redirect_valid;

`ifdef IFU_HALT_DETECT_EN
    if (pushEn && (bus.mem_data_out[DATA_W-1 -: OPC_W] == OPC_HALT)) begin
      state_d = ST_IDLE;
    end
`else
`endif

    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
      if ((state_q == ST_WAIT) && (latCnt_q != '0)) begin
        squash_d = 1'b1;
      end
    end
  end

  assign bus.mem_read_enable = issue;
  assign bus.mem_address     = issue ? pc_q : '0;
  assign bus.fetch_active    = (state_q != ST_IDLE);

  ifu_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (pushEn),
    .data_i  ({reqPc_q, bus.mem_data_out}),
    .pop_i   (bus.instr_ready),
    .clear_i (bus.redirect_valid),
    .data_o  (fifoHead),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign bus.instr_valid = !fifoEmpty;
  assign bus.instr_pc    = fifoHead[ENT_W-1 -: ADDR_W];
  assign bus.instr       = fifoHead[DATA_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A behavioural model (a queue
// for the prefetch buffer plus a record of the single outstanding read)
// predicts every output on every cycle; directed phases pin the model with
// hand-computed sequences, then a long randomized phase exercises stalls,
// back-pressure, redirects and resets.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 4;
  localparam int MEM_LAT = 1;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
  } entry_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cycleNo = 0;
  int   haltAddr = -1;

  logic [15:0] readAddrs[$];
  int          readCycles[$];
  entry_t      deliv[$];

  entry_t      q[$];
  bit          mActive, mOut, mSquash;
  int          mLeft;
  logic [15:0] mNextPc, mOutPc;

  logic [15:0] pipeAddr;
  logic        pipeVal;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .MEM_LAT  (MEM_LAT),
    .RESET_PC (16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Memory contents: the program from the first directed test, then a hash
  // that never produces the HALT opcode
  function automatic logic [15:0] memWord(input logic [15:0] a);
    logic [15:0] h;
    if (int'(a) == haltAddr) return 16'hE000;
    case (a)
      16'd0:   return 16'h0B00;
      16'd1:   return 16'h2B00;
      16'd2:   return 16'h4B00;
      16'd3:   return 16'h6B00;
      16'd4:   return 16'hA005;
      16'd5:   return 16'h9805;
      default: begin
        h = a * 16'h03A1 + 16'h0015;
        return h & 16'hDFFF;
      end
    endcase
  endfunction

  // One-cycle-latency memory: data for a read appears the cycle after the strobe
  always @(posedge clk) begin
    pipeAddr <= bus.mem_address;
    pipeVal  <= bus.mem_read_enable;
  end

  assign bus.mem_data_out = (pipeVal === 1'b1) ? memWord(pipeAddr) : 16'hDEAD;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] readAt(input int i);
    return (readAddrs.size() > i) ? 32'(readAddrs[i]) : 32'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] delivAt(input int i);
    return (deliv.size() > i) ? 32'(deliv[i]) : 32'hBAD0_BAD0;
  endfunction

  // Reference model step: check this cycle's outputs, then advance one cycle
  task automatic modelStep();
    bit          expIssue, pushNow, popNow;
    int          cnt;
    logic [15:0] w;
    if (!reset) begin
      q.delete();
      mActive = 0; mOut = 0; mSquash = 0; mLeft = 0;
      mNextPc = 16'h0000;
      checkOutput("reset_rd_en",    32'(bus.mem_read_enable), 32'h0);
      checkOutput("reset_rd_addr",  32'(bus.mem_address),     32'h0);
      checkOutput("reset_valid",    32'(bus.instr_valid),     32'h0);
      checkOutput("reset_instr",    32'(bus.instr),           32'h0);
      checkOutput("reset_instr_pc", 32'(bus.instr_pc),        32'h0);
      checkOutput("reset_active",   32'(bus.fetch_active),    32'h0);
      return;
    end
    cnt = q.size();
    expIssue = mActive && !bus.mem_busy && (cnt < DEPTH) && !mOut && !bus.redirect_valid;
    checkOutput("rd_en",        32'(bus.mem_read_enable), 32'(expIssue));
    checkOutput("rd_addr",      32'(bus.mem_address),     expIssue ? 32'(mNextPc) : 32'h0);
    checkOutput("instr_valid",  32'(bus.instr_valid),     32'(cnt > 0));
    checkOutput("instr",        32'(bus.instr),           (cnt > 0) ? 32'(q[0].word) : 32'h0);
    checkOutput("instr_pc",     32'(bus.instr_pc),        (cnt > 0) ? 32'(q[0].pc) : 32'h0);
    checkOutput("fetch_active", 32'(bus.fetch_active),    32'(mActive));

    pushNow = mOut && (mLeft == 0) && !mSquash && !bus.redirect_valid;
    popNow  = bus.instr_ready && (cnt > 0) && !bus.redirect_valid;
    w = memWord(mOutPc);
    if (bus.redirect_valid) begin
      q.delete();
      mNextPc = bus.redirect_pc;
      if (mOut) mSquash = 1;
    end else begin
      if (popNow) void'(q.pop_front());
      if (pushNow) q.push_back('{pc: mOutPc, word: w});
    end
    if (mOut) begin
      if (mLeft == 0) mOut = 0;
      else mLeft--;
    end
    if (bus.start && !mActive) mActive = 1;
`ifdef IFU_HALT_DETECT_EN
    if (pushNow && (w[15:13] == 3'b111)) mActive = 0;
`endif
    if (expIssue) begin
      mOut    = 1;
      mLeft   = MEM_LAT - 1;
      mOutPc  = mNextPc;
      mSquash = 0;
      mNextPc = mNextPc + 16'd1;
    end
  endtask

  // Per-cycle observer: logs reads and deliveries, then runs the model compare
  initial begin
    forever begin
      @(negedge clk);
      cycleNo++;
      if (reset && bus.mem_read_enable) begin
        readAddrs.push_back(bus.mem_address);
        readCycles.push_back(cycleNo);
      end
      if (reset && bus.instr_valid && bus.instr_ready && !bus.redirect_valid)
        deliv.push_back({bus.instr_pc, bus.instr});
      modelStep();
    end
  end

  task automatic applyStimulus(input bit st, input bit busy, input bit rdy, input bit rv, input logic [15:0] rpc);
    @(posedge clk); #1;
    bus.start          = st;
    bus.mem_busy       = busy;
    bus.instr_ready    = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 0; bus.mem_busy = 0; bus.instr_ready = 0;
    bus.redirect_valid = 0; bus.redirect_pc = '0;
    hold(2);
    reset = 1'b1;
    readAddrs.delete();
    readCycles.delete();
    deliv.delete();
  endtask

  task automatic waitRead(input string name, input logic [15:0] addr, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (bus.mem_read_enable && bus.mem_address == addr) found = 1;
    end
    checkOutput(name, 32'(found), 32'h1);
  endtask

  initial begin
    int n0, mark;
    bus.start = 0; bus.mem_busy = 0; bus.instr_ready = 0;
    bus.redirect_valid = 0; bus.redirect_pc = '0;

    // Straight-line program delivery
    doReset();
    applyStimulus(1, 0, 1, 0, 16'h0);
    applyStimulus(0, 0, 1, 0, 16'h0);
    hold(20);
    checkOutput("seq_0", delivAt(0), {16'h0000, 16'h0B00});
    checkOutput("seq_1", delivAt(1), {16'h0001, 16'h2B00});
    checkOutput("seq_2", delivAt(2), {16'h0002, 16'h4B00});
    checkOutput("seq_3", delivAt(3), {16'h0003, 16'h6B00});
    checkOutput("seq_4", delivAt(4), {16'h0004, 16'hA005});
    checkOutput("seq_5", delivAt(5), {16'h0005, 16'h9805});
    checkOutput("read_spacing_a", 32'(readCycles[1] - readCycles[0]), 32'd2);
    checkOutput("read_spacing_b", 32'(readCycles[5] - readCycles[4]), 32'd2);
    checkOutput("read_addr_5", readAt(5), 32'h5);

    // Back-pressure: FIFO fills and fetching stops at four reads
    doReset();
    applyStimulus(1, 0, 0, 0, 16'h0);
    applyStimulus(0, 0, 0, 0, 16'h0);
    hold(15);
    checkOutput("full_reads",    32'(readAddrs.size()), 32'd4);
    checkOutput("full_valid",    32'(bus.instr_valid),  32'h1);
    checkOutput("full_instr_pc", 32'(bus.instr_pc),     32'h0);
    checkOutput("full_instr",    32'(bus.instr),        32'h0B00);
    applyStimulus(0, 0, 1, 0, 16'h0);
    applyStimulus(0, 0, 0, 0, 16'h0);
    hold(4);
    checkOutput("after_pop_reads", 32'(readAddrs.size()), 32'd5);
    checkOutput("after_pop_addr",  readAt(4),             32'h4);

    // Memory busy during WAIT, then redirect during WAIT
    doReset();
    applyStimulus(1, 0, 1, 0, 16'h0);
    applyStimulus(0, 0, 1, 0, 16'h0);
    waitRead("wait_read_2", 16'h2, 20);
    applyStimulus(0, 1, 1, 0, 16'h0);
    n0 = readAddrs.size();
    hold(4);
    applyStimulus(0, 0, 1, 0, 16'h0);
    checkOutput("busy_no_reads", 32'(readAddrs.size()), 32'(n0));
    @(negedge clk);
    checkOutput("busy_release_en",   32'(bus.mem_read_enable), 32'h1);
    checkOutput("busy_release_addr", 32'(bus.mem_address),     32'h3);
    mark = deliv.size();
    applyStimulus(0, 0, 1, 1, 16'h0040);
    applyStimulus(0, 0, 1, 0, 16'h0);
    @(negedge clk);
    checkOutput("redir_empty",     32'(bus.instr_valid),     32'h0);
    checkOutput("redir_read_en",   32'(bus.mem_read_enable), 32'h1);
    checkOutput("redir_read_addr", 32'(bus.mem_address),     32'h0040);
    hold(10);
    checkOutput("busy_word2",     delivAt(2),    {16'h0002, 16'h4B00});
    checkOutput("redir_first",    delivAt(mark), {16'h0040, 16'hC855});

    // PC wrap after redirect in IDLE
    doReset();
    applyStimulus(0, 0, 1, 1, 16'hFFFF);
    applyStimulus(1, 0, 1, 0, 16'h0);
    applyStimulus(0, 0, 1, 0, 16'h0);
    hold(6);
    checkOutput("wrap_read_0", readAt(0), 32'hFFFF);
    checkOutput("wrap_read_1", readAt(1), 32'h0000);
    checkOutput("wrap_deliv",  delivAt(0), {16'hFFFF, 16'hDC74});

`ifdef IFU_HALT_DETECT_EN
    // HALT word stops fetching after it is captured
    doReset();
    haltAddr = 2;
    applyStimulus(1, 0, 1, 0, 16'h0);
    applyStimulus(0, 0, 1, 0, 16'h0);
    hold(15);
    checkOutput("halt_active", 32'(bus.fetch_active), 32'h0);
    checkOutput("halt_reads",  32'(readAddrs.size()), 32'd3);
    checkOutput("halt_deliv",  delivAt(2),            {16'h0002, 16'hE000});
    haltAddr = -1;
`endif

    // Randomized traffic against the model
    doReset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 15) == 0,
                      $urandom_range(0, 4) == 0,
                      $urandom_range(0, 9) < 7,
                      $urandom_range(0, 39) == 0,
                      16'($urandom));
      end
    end
    hold(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
